// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding, default HLT opcode
// and a small elaboration-time helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [7:0] HLT_OPCODE_DEF = 8'h0A;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/program_loader_run_watchdog.sv
// run_watchdog: up-counter that is loaded with zero and flags terminal count.
// Ports: clk, clear (sync reset), load (restart at 0), inc (count up),
//        terminal (compare value), tc (count == terminal).
module run_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/program_loader.sv
// program_loader: streams a program into CPU RAM from address 0, holds the CPU
// in clear while loading, releases it and watches for HLT or a run timeout.
// Ports: clk, clear (sync reset); start; in_valid/in_data/in_last/in_ready
//        stream; ram_we/ram_addr/ram_wdata RAM write; cpu_instr from CPU;
//        cpu_clear to CPU; busy, halted, timeout, overflow status.
// Build option: define ZERO_FILL_EN to zero the RAM above the last loaded byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W     = 4,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] HLT_OPCODE = DATA_W'(HLT_OPCODE_DEF),
    parameter int                CLEAR_CYC  = 2,
    parameter int                MAX_RUN    = 150
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_clear,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic              overflow
);

    localparam int CNT_W = $clog2(max_int(MAX_RUN, CLEAR_CYC) + 1);
    localparam logic [ADDR_W:0]  TOP      = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN - 1);

    state_t            state, state_d;
    logic [ADDR_W:0]   addr_cnt;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              cnt_clr, cnt_inc;
    logic              clr_flags, set_halt, set_to, set_ovf;
    logic              wd_load, wd_inc, wd_tc;
    logic [CNT_W-1:0]  wd_term;

    // One counter times both the clear hold and the run window.
    run_watchdog #(.W(CNT_W)) u_wd (
        .clk      (clk),
        .clear    (clear),
        .load     (wd_load),
        .inc      (wd_inc),
        .terminal (wd_term),
        .tc       (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= ST_IDLE;
            addr_cnt  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state  <= state_d;
            ram_we <= wr_en;
            if (wr_en) begin
                ram_addr  <= addr_cnt[ADDR_W-1:0];
                ram_wdata <= wr_data;
            end
            if (cnt_clr) begin
                addr_cnt <= '0;
            end else if (cnt_inc) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (clr_flags) begin
                halted   <= 1'b0;
                timeout  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (set_halt) halted   <= 1'b1;
                if (set_to)   timeout  <= 1'b1;
                if (set_ovf)  overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state;
        wr_en     = 1'b0;
        wr_data   = in_data;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        clr_flags = 1'b0;
        set_halt  = 1'b0;
        set_to    = 1'b0;
        set_ovf   = 1'b0;
        wd_load   = 1'b0;
        wd_inc    = 1'b0;
        wd_term   = RUN_LAST;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    cnt_clr   = 1'b1;
                    clr_flags = 1'b1;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                    if (in_last) begin
`ifdef ZERO_FILL_EN
                        if (addr_cnt != TOP) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d = ST_RELEASE;
                            wd_load = 1'b1;
                        end
`else
                        state_d = ST_RELEASE;
                        wd_load = 1'b1;
`endif
                    end else if (addr_cnt == TOP) begin
                        // Last slot taken with more to come: keep CPU frozen.
                        set_ovf = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FILL: begin
`ifdef ZERO_FILL_EN
                wr_en   = 1'b1;
                wr_data = '0;
                cnt_inc = 1'b1;
                if (addr_cnt == TOP) begin
                    state_d = ST_RELEASE;
                    wd_load = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RELEASE: begin
                wd_term = REL_LAST;
                if (wd_tc) begin
                    state_d = ST_RUN;
                    wd_load = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_RUN: begin
                // HLT takes priority over the final timeout cycle.
                if (cpu_instr == HLT_OPCODE) begin
                    set_halt = 1'b1;
                    state_d  = ST_DONE;
                end else if (wd_tc) begin
                    set_to  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_LOAD);
    assign cpu_clear = (state != ST_RUN);
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);

endmodule
